// File: rtl/fc_score_gen_if.sv
// ---------------------------------------------------------------------------
// fc_score_gen_if
//
// Purpose
//   Bundles the feature-beat input handshake and the class-score output
//   handshake of fc_score_gen into a single interface. The scores num0..num9
//   are kept as ten separate signals so they connect one-to-one onto the
//   score inputs of the downstream argmax stage.
//
// Parameters
//   w1  signed accumulator / score width (must be >= 2*wd)
//   wd  signed feature and weight width
//
// Signals
//   in_valid    feature beat valid                    (master -> slave)
//   in_ready    block can accept a beat               (slave  -> master)
//   in_feature  signed feature value, wd bits         (master -> slave)
//   in_weights  ten signed weights, class k in
//               bits [wd*(k+1)-1 : wd*k]              (master -> slave)
//   in_last     final beat of the current vector      (master -> slave)
//   out_valid   num0..num9 hold a finished vector     (slave  -> master)
//   out_ready   downstream takes the scores           (master -> slave)
//   num0..num9  signed class scores, w1 bits each     (slave  -> master)
//
// Modports
//   master  the side that feeds beats and consumes scores
//   slave   the score generator itself
// ---------------------------------------------------------------------------
interface fc_score_gen_if #(
  parameter int w1 = 64,
  parameter int wd = 16
);

  logic                   in_valid;
  logic                   in_ready;
  logic signed [wd-1:0]   in_feature;
  logic [10*wd-1:0]       in_weights;
  logic                   in_last;

  logic                   out_valid;
  logic                   out_ready;
  logic signed [w1-1:0]   num0;
  logic signed [w1-1:0]   num1;
  logic signed [w1-1:0]   num2;
  logic signed [w1-1:0]   num3;
  logic signed [w1-1:0]   num4;
  logic signed [w1-1:0]   num5;
  logic signed [w1-1:0]   num6;
  logic signed [w1-1:0]   num7;
  logic signed [w1-1:0]   num8;
  logic signed [w1-1:0]   num9;

  modport master (
    output in_valid,
    input  in_ready,
    output in_feature,
    output in_weights,
    output in_last,
    input  out_valid,
    output out_ready,
    input  num0, num1, num2, num3, num4,
    input  num5, num6, num7, num8, num9
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_feature,
    input  in_weights,
    input  in_last,
    output out_valid,
    input  out_ready,
    output num0, num1, num2, num3, num4,
    output num5, num6, num7, num8, num9
  );

endinterface

// File: rtl/fc_score_gen.sv
// ---------------------------------------------------------------------------
// fc_score_gen
//
// Purpose
//   Fully-connected output layer for a ten-class classifier. Each accepted
//   beat carries one feature and the ten weights that multiply it; the
//   block multiplies the feature by every weight in parallel and adds the
//   ten full-precision products into ten running accumulators. When the
//   beat flagged in_last has been absorbed the block stops taking beats and
//   presents the ten accumulators as class scores until the downstream
//   argmax stage takes them with out_ready, which also clears the
//   accumulators for the next vector. Vectors may have any number of beats,
//   including one.
//
// Ports
//   clk    sole clock, rising edge
//   rst_n  synchronous active-low reset; clears accumulators and returns to
//          accumulation, dominating every other input
//   bus    fc_score_gen_if.slave: beat handshake in, score handshake out
//
// Parameters
//   w1  signed accumulator / score width (must be >= 2*wd)
//   wd  signed feature and weight width
//
// Build option
//   FC_SAT_EN  when defined, every accumulation clamps to the signed w1
//              range on overflow; when undefined, accumulation wraps modulo
//              2^w1 and no clamping logic exists.
// ---------------------------------------------------------------------------
module fc_score_gen #(
  parameter int w1 = 64,
  parameter int wd = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  fc_score_gen_if.slave  bus
);

  // Full-precision product width of one feature times one weight.
  localparam int pw = 2 * wd;

`ifdef FC_SAT_EN
  localparam logic signed [w1-1:0] acc_max = {1'b0, {(w1-1){1'b1}}};
  localparam logic signed [w1-1:0] acc_min = {1'b1, {(w1-1){1'b0}}};
`endif

  typedef enum logic {
    ACC,
    HOLD
  } state_t;

  state_t               state;
  state_t               state_next;

  logic                 in_ready_int;
  logic                 out_valid_int;
  logic                 transfer;
  logic                 clear;

  logic signed [w1-1:0] acc      [10];
  logic signed [w1-1:0] acc_next [10];

  assign transfer = bus.in_valid && in_ready_int;
  assign clear    = (state == HOLD) && bus.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. The last beat is only honoured when it is actually
  // transferred, and in HOLD nothing but out_ready moves the machine.
  always_comb begin
    state_next = state;
    case (state)
      ACC:     if (transfer && bus.in_last) state_next = HOLD;
      HOLD:    if (bus.out_ready)           state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  // Output decode. in_ready is deliberately low in HOLD, so a beat offered
  // in the same cycle as out_ready waits one cycle and lands in a cleared
  // accumulator set.
  always_comb begin
    in_ready_int  = 1'b0;
    out_valid_int = 1'b0;
    case (state)
      ACC:     in_ready_int  = 1'b1;
      HOLD:    out_valid_int = 1'b1;
      default: in_ready_int  = 1'b0;
    endcase
  end

  // Ten parallel multiply-accumulate lanes. Each product is formed at full
  // 2*wd precision and sign-extended to w1 before the add.
  always_comb begin
    logic signed [pw-1:0] prod;
    logic signed [w1-1:0] ext;
    logic signed [w1-1:0] sum;
    prod = '0;
    ext  = '0;
    sum  = '0;
    for (int k = 0; k < 10; k++) begin
      prod = pw'(bus.in_feature) * pw'($signed(bus.in_weights[k*wd +: wd]));
      ext  = w1'(prod);
      sum  = acc[k] + ext;
`ifdef FC_SAT_EN
      // Overflow is only possible when both operands share a sign and the
      // wrapped result shows the opposite sign.
      if (!acc[k][w1-1] && !ext[w1-1] && sum[w1-1]) begin
        sum = acc_max;
      end else if (acc[k][w1-1] && ext[w1-1] && !sum[w1-1]) begin
        sum = acc_min;
      end
`endif
      acc_next[k] = sum;
    end
  end

  // Accumulator bank. Reset and the HOLD hand-off both zero every lane, so
  // a partial or pending vector never reaches the scores.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 10; k++) acc[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < 10; k++) acc[k] <= '0;
    end else if (transfer) begin
      for (int k = 0; k < 10; k++) acc[k] <= acc_next[k];
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;

  // Scores are the accumulators themselves, so they are stable for as long
  // as the block sits in HOLD.
  assign bus.num0 = acc[0];
  assign bus.num1 = acc[1];
  assign bus.num2 = acc[2];
  assign bus.num3 = acc[3];
  assign bus.num4 = acc[4];
  assign bus.num5 = acc[5];
  assign bus.num6 = acc[6];
  assign bus.num7 = acc[7];
  assign bus.num8 = acc[8];
  assign bus.num9 = acc[9];

endmodule

// File: tb/tb_fc_score_gen.sv
// ---------------------------------------------------------------------------
// tb_fc_score_gen
//
// Self-checking bench for fc_score_gen. A 64-bit instance takes directed
// vectors and a run of random vectors scored against a plain-arithmetic
// reference; a 32-bit instance covers the overflow behaviour, whose expected
// result depends on whether FC_SAT_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_fc_score_gen;

  localparam int WD  = 16;
  localparam int W1  = 64;
  localparam int W1N = 32;

  logic clk;
  logic rst_n;

  int check_count = 0;
  int pass_count  = 0;

  longint model_acc [10];

  fc_score_gen_if #(.w1(W1),  .wd(WD)) bus64 ();
  fc_score_gen_if #(.w1(W1N), .wd(WD)) bus32 ();

  fc_score_gen #(.w1(W1), .wd(WD)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus64.slave)
  );

  fc_score_gen #(.w1(W1N), .wd(WD)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32.slave)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run never reaches its summary.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout, want summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, expected);
    end
  endtask

  function automatic longint num64(input int k);
    case (k)
      0: return bus64.num0;
      1: return bus64.num1;
      2: return bus64.num2;
      3: return bus64.num3;
      4: return bus64.num4;
      5: return bus64.num5;
      6: return bus64.num6;
      7: return bus64.num7;
      8: return bus64.num8;
      default: return bus64.num9;
    endcase
  endfunction

  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic signed [WD-1:0] feature,
                               input logic [10*WD-1:0] weights, input logic last,
                               input logic ready);
    bus64.in_valid   = valid;
    bus64.in_feature = feature;
    bus64.in_weights = weights;
    bus64.in_last    = last;
    bus64.out_ready  = ready;
  endtask

  task automatic checkScores(input string tag, input longint expv [10]);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("%s num%0d", tag, k), num64(k), expv[k]);
    end
  endtask

  task automatic checkZero(input string tag);
    longint z [10];
    for (int k = 0; k < 10; k++) z[k] = 0;
    checkScores(tag, z);
  endtask

  task automatic drain64();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    clockEdge();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [10*WD-1:0]     w;
    logic [10*WD-1:0]     w5;
    logic signed [WD-1:0] f;
    longint               expv [10];
    int                   nbeats;
    int                   hold_cycles;

    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    bus32.in_valid   = 1'b0;
    bus32.in_feature = '0;
    bus32.in_weights = '0;
    bus32.in_last    = 1'b0;
    bus32.out_ready  = 1'b0;

    // Reset state.
    clockEdge();
    clockEdge();
    checkOutput("reset in_ready", bus64.in_ready, 1);
    checkOutput("reset out_valid", bus64.out_valid, 0);
    checkZero("reset");
    rst_n = 1'b1;
    clockEdge();

    // Two-beat vector: feature 3 with weights k+1, then feature -2 with all 5.
    for (int k = 0; k < 10; k++) w[k*WD +: WD] = WD'(k + 1);
    for (int k = 0; k < 10; k++) w5[k*WD +: WD] = WD'(5);
    applyStimulus(1'b1, 16'sd3, w, 1'b0, 1'b0);
    clockEdge();
    checkOutput("two-beat mid out_valid", bus64.out_valid, 0);
    applyStimulus(1'b1, -16'sd2, w5, 1'b1, 1'b0);
    clockEdge();
    checkOutput("two-beat out_valid", bus64.out_valid, 1);
    checkOutput("two-beat in_ready", bus64.in_ready, 0);
    for (int k = 0; k < 10; k++) expv[k] = 3 * (k + 1) - 10;
    checkScores("two-beat", expv);

    // Long HOLD with a beat offered the whole time: nothing may be absorbed.
    applyStimulus(1'b1, 16'sd9, w5, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      clockEdge();
      checkOutput("hold in_ready", bus64.in_ready, 0);
      checkOutput("hold out_valid", bus64.out_valid, 1);
      checkOutput("hold num0", num64(0), -7);
      checkOutput("hold num9", num64(9), 20);
    end
    applyStimulus(1'b1, 16'sd9, w5, 1'b1, 1'b1);
    clockEdge();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("release in_ready", bus64.in_ready, 1);
    checkOutput("release out_valid", bus64.out_valid, 0);
    checkZero("release");

    // Single beat with the most negative feature and weight.
    w = '0;
    w[0 +: WD] = 16'h8000;
    applyStimulus(1'b1, -16'sd32768, w, 1'b1, 1'b0);
    clockEdge();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("single out_valid", bus64.out_valid, 1);
    for (int k = 0; k < 10; k++) expv[k] = 0;
    expv[0] = 1073741824;
    checkScores("single", expv);
    drain64();

    // Reset after two of three beats; reset must win over a last beat.
    applyStimulus(1'b1, 16'sd5, w5, 1'b0, 1'b0);
    clockEdge();
    clockEdge();
    applyStimulus(1'b1, 16'sd5, w5, 1'b1, 1'b0);
    rst_n = 1'b0;
    clockEdge();
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("midreset out_valid", bus64.out_valid, 0);
    checkOutput("midreset in_ready", bus64.in_ready, 1);
    checkZero("midreset");
    clockEdge();
    checkOutput("postreset out_valid", bus64.out_valid, 0);
    w = '0;
    w[3*WD +: WD] = 16'sd7;
    applyStimulus(1'b1, 16'sd1, w, 1'b1, 1'b0);
    clockEdge();
    checkOutput("postreset vec out_valid", bus64.out_valid, 1);
    checkOutput("postreset num3", num64(3), 7);
    checkOutput("postreset num0", num64(0), 0);

    // Beat offered in the same cycle as out_ready waits one cycle.
    w = '0;
    w[1*WD +: WD] = 16'sd4;
    applyStimulus(1'b1, 16'sd4, w, 1'b1, 1'b1);
    clockEdge();
    checkOutput("overlap in_ready", bus64.in_ready, 1);
    checkOutput("overlap out_valid", bus64.out_valid, 0);
    checkOutput("overlap num1", num64(1), 0);
    checkOutput("overlap num3", num64(3), 0);
    applyStimulus(1'b1, 16'sd4, w, 1'b1, 1'b0);
    clockEdge();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("overlap taken out_valid", bus64.out_valid, 1);
    checkOutput("overlap taken num1", num64(1), 16);
    drain64();

    // Random vectors against the reference sums.
    for (int v = 0; v < 40; v++) begin
      for (int k = 0; k < 10; k++) model_acc[k] = 0;
      nbeats = $urandom_range(1, 6);
      for (int b = 0; b < nbeats; b++) begin
        while ($urandom_range(0, 3) == 0) begin
          applyStimulus(1'b0, WD'($urandom), '0, 1'($urandom), 1'($urandom));
          clockEdge();
          checkOutput("rand idle in_ready", bus64.in_ready, 1);
          checkOutput("rand idle out_valid", bus64.out_valid, 0);
        end
        f = WD'($urandom);
        for (int k = 0; k < 10; k++) w[k*WD +: WD] = WD'($urandom);
        applyStimulus(1'b1, f, w, (b == nbeats - 1), 1'($urandom));
        clockEdge();
        for (int k = 0; k < 10; k++) begin
          model_acc[k] += longint'(f) * longint'($signed(w[k*WD +: WD]));
        end
        if (b != nbeats - 1) begin
          checkOutput("rand mid out_valid", bus64.out_valid, 0);
        end
      end
      checkOutput("rand out_valid", bus64.out_valid, 1);
      checkScores($sformatf("rand v%0d", v), model_acc);
      hold_cycles = $urandom_range(0, 3);
      for (int c = 0; c < hold_cycles; c++) begin
        applyStimulus(1'($urandom), WD'($urandom), {5{32'($urandom)}}, 1'($urandom), 1'b0);
        clockEdge();
        checkOutput("rand hold in_ready", bus64.in_ready, 0);
        checkOutput("rand hold num0", num64(0), model_acc[0]);
        checkOutput("rand hold num9", num64(9), model_acc[9]);
      end
      applyStimulus(1'($urandom), WD'($urandom), {5{32'($urandom)}}, 1'($urandom), 1'b1);
      clockEdge();
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("rand drain in_ready", bus64.in_ready, 1);
      checkOutput("rand drain num0", num64(0), 0);
      checkOutput("rand drain num5", num64(5), 0);
    end

    // 32-bit instance: three beats of 32767*32767 overflow on the third.
    bus32.in_valid   = 1'b1;
    bus32.in_feature = 16'sd32767;
    bus32.in_weights = '0;
    bus32.in_weights[0 +: WD] = 16'sd32767;
    bus32.in_last    = 1'b0;
    clockEdge();
    clockEdge();
    checkOutput("w32 two-beat num0", longint'(bus32.num0), 2147352578);
    checkOutput("w32 two-beat out_valid", bus32.out_valid, 0);
    bus32.in_last = 1'b1;
    clockEdge();
    bus32.in_valid = 1'b0;
    bus32.in_last  = 1'b0;
    checkOutput("w32 out_valid", bus32.out_valid, 1);
`ifdef FC_SAT_EN
    checkOutput("w32 num0 clamped", longint'(bus32.num0), 2147483647);
`else
    checkOutput("w32 num0 wrapped", longint'(bus32.num0), -1073938429);
`endif
    checkOutput("w32 num1", longint'(bus32.num1), 0);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
